// File: rtl/alu_issue_ctrl.sv
// Issue stage for the registered 4-bit ALU: command FIFO, one issue per cycle,
// 2-entry tagged result buffer with credit-based throttling against backpressure.
module alu_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [4:0]       alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [1:0]       f_op [DEPTH];
  logic [3:0]       f_a  [DEPTH];
  logic [3:0]       f_b  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_count;

  logic             pending;
  logic [TAG_W-1:0] pend_tag, tag_cnt;

  logic [4:0]       rb_data [2];
  logic [TAG_W-1:0] rb_tag  [2];
  logic             rb_wr, rb_rd;
  logic [1:0]       res_count;

  logic             push, issue, res_pop;
  logic [2:0]       in_flight;

  assign in_ready  = (fifo_count < FULL);
  assign push      = in_valid && in_ready;
  assign res_valid = (res_count != 2'd0);
  assign res_pop   = res_valid && res_ready;
  assign res_data  = rb_data[rb_rd];
  assign res_tag   = rb_tag[rb_rd];
  assign busy      = (fifo_count != '0) || pending || res_valid;

  // A slot freed by this cycle's pop can be reused by this cycle's issue,
  // which is what keeps a full-rate stream running with only two credits.
  assign in_flight = {1'b0, res_count} + {2'b0, pending};
  assign issue     = (fifo_count != '0) && (in_flight < (3'd2 + {2'b0, res_pop}));

  always_comb begin
    alu_opcode = 2'd0;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    if (issue) begin
      alu_opcode = f_op[rd_ptr];
      alu_a      = f_a[rd_ptr];
      alu_b      = f_b[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wr_ptr] <= in_opcode;
      f_a[wr_ptr]  <= in_a;
      f_b[wr_ptr]  <= in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pending    <= 1'b0;
      pend_tag   <= '0;
      tag_cnt    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      pending <= issue;
      if (issue) begin
        pend_tag <= tag_cnt;
        tag_cnt  <= tag_cnt + 1'b1;
      end
    end
  end

  // alu_c is the ALU register output for the op issued last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rb_data[i] <= '0;
        rb_tag[i]  <= '0;
      end
      rb_wr     <= 1'b0;
      rb_rd     <= 1'b0;
      res_count <= 2'd0;
    end else begin
      if (pending) begin
        rb_data[rb_wr] <= alu_c;
        rb_tag[rb_wr]  <= pend_tag;
        rb_wr          <= ~rb_wr;
      end
      if (res_pop) rb_rd <= ~rb_rd;
      case ({pending, res_pop})
        2'b10:   res_count <= res_count + 2'd1;
        2'b01:   res_count <= res_count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered 4-bit ALU model on the alu_* side.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_opcode = '0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_c;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [4:0] res_data;
  logic [2:0] res_tag;
  logic       busy;

  int checks = 0, errors = 0;
  int cyc = 0, issued = 0, popped = 0;
  logic [4:0] got_d[$];
  logic [2:0] got_t[$];
  int         got_c[$];

  alu_issue_ctrl #(.DEPTH(4), .TAG_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] alu_ref(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    logic [4:0] ea, eb;
    ea = {a[3], a};
    eb = {b[3], b};
    case (op)
      2'd0:    return ea + eb;
      2'd1:    return ea - eb;
      2'd2:    return ~ea;
      default: return {4'b0, |b};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) alu_c <= '0;
    else       alu_c <= alu_ref(alu_opcode, alu_a, alu_b);

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) popped = issued;
    else begin
      if (|{alu_opcode, alu_a, alu_b}) issued++;
      if (res_valid && res_ready) begin
        got_d.push_back(res_data);
        got_t.push_back(res_tag);
        got_c.push_back(cyc);
        popped++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bit ok = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL push_timeout: in_ready=0 required 1"); end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < 300; k++) begin
      if (got_d.size() >= n) break;
      @(posedge clk);
    end
    #1;
    checks++;
    if (got_d.size() < n) begin
      errors++; $display("FAIL wait_results: got %0d required %0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, res_valid, res_data, res_tag, alu_opcode, alu_a, alu_b, busy} !== {1'b1, 20'd0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h tag=%0d alu=%h/%h/%h busy=%b required rdy=1 rest 0",
               in_ready, res_valid, res_data, res_tag, alu_opcode, alu_a, alu_b, busy);
    end
  endtask

  task automatic test_single();
    do_reset(); res_ready = 1'b1;
    push(2'd0, 4'd3, 4'd2);
    @(negedge clk);
    checks++;
    if ({alu_opcode, alu_a, alu_b} !== {2'd0, 4'd3, 4'd2}) begin
      errors++; $display("FAIL single_issue: alu=%h/%h/%h required 0/3/2", alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_latency: vld=%b busy=%b required 0 1", res_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 5'd5 || res_tag !== 3'd0) begin
      errors++; $display("FAIL single_result: vld=%b data=%0d tag=%0d required 1 5 0", res_valid, res_data, res_tag);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%b vld=%b required 0 0", busy, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_d [4] = '{5'b11001, 5'b11010, 5'd1, 5'd0};
    int base;
    do_reset(); res_ready = 1'b1;
    base = got_d.size();
    push(2'd1, 4'b1101, 4'd4);
    push(2'd2, 4'd5, 4'd0);
    push(2'd3, 4'd0, 4'd8);
    push(2'd3, 4'd0, 4'd0);
    wait_n(base + 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i >= got_d.size()) break;
      checks++;
      if (got_d[base+i] !== exp_d[i] || got_t[base+i] !== 3'(i)) begin
        errors++; $display("FAIL b2b_result%0d: data=%b tag=%0d required %b %0d", i, got_d[base+i], got_t[base+i], exp_d[i], i);
      end
      if (i > 0) begin
        checks++;
        if (got_c[base+i] !== got_c[base+i-1] + 1) begin
          errors++; $display("FAIL b2b_rate%0d: gap=%0d required 1", i, got_c[base+i] - got_c[base+i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] op [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] a  [6] = '{4'd1, 4'd2, 4'd0, 4'b1000, 4'd0, 4'b1000};
    logic [3:0] b  [6] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd3, 4'b1000};
    logic [4:0] exp_d [6] = '{5'd2, 5'd3, 5'b11111, 5'b00111, 5'd1, 5'b10000};
    int base;
    do_reset();
    base = got_d.size();
    for (int i = 0; i < 6; i++) push(op[i], a[i], b[i]);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%b required 0", in_ready); end
    checks++;
    if (issued - popped != 2) begin errors++; $display("FAIL bp_issued: in_flight=%0d required 2", issued - popped); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 5'd2 || res_tag !== 3'd0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: vld=%b data=%0d tag=%0d rdy=%b required 1 2 0 0", k, res_valid, res_data, res_tag, in_ready);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_n(base + 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i >= got_d.size()) break;
      checks++;
      if (got_d[base+i] !== exp_d[i] || got_t[base+i] !== 3'(i)) begin
        errors++; $display("FAIL bp_drain%0d: data=%b tag=%0d required %b %0d", i, got_d[base+i], got_t[base+i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_tag_wrap();
    int base;
    do_reset(); res_ready = 1'b1;
    base = got_d.size();
    for (int i = 0; i < 9; i++) push(2'd0, 4'(i % 4), 4'd0);
    wait_n(base + 9);
    for (int i = 0; i < 9; i++) begin
      if (base + i >= got_d.size()) break;
      checks++;
      if (got_t[base+i] !== 3'(i % 8) || got_d[base+i] !== 5'(i % 4)) begin
        errors++; $display("FAIL wrap%0d: tag=%0d data=%0d required %0d %0d", i, got_t[base+i], got_d[base+i], i % 8, i % 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    for (int i = 0; i < 5; i++) push(2'd0, 4'd1, 4'd1);
    // one pop frees a credit: next edge issues while pushing, leaving 3 queued and 1 pending
    in_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_pre: busy=%b rdy=%b required 1 1", busy, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: vld=%b rdy=%b busy=%b required 0 1 0", res_valid, in_ready, busy);
    end
    @(posedge clk); #1 reset = 1'b0; res_ready = 1'b1;
    base = got_d.size();
    push(2'd1, 4'd6, 4'd2);
    wait_n(base + 1);
    checks++;
    if (got_d.size() <= base || got_t[base] !== 3'd0 || got_d[base] !== 5'd4) begin
      errors++; $display("FAIL mid_restart: results=%0d required tag 0 data 4 after reset", got_d.size() - base);
    end
  endtask

  task automatic test_toggle();
    int base, worst = 0;
    do_reset();
    base = got_d.size();
    fork
      for (int i = 0; i < 10; i++) push(2'(i % 2), 4'(i + 1), 4'd3);
      for (int k = 0; k < 200; k++) begin
        if (got_d.size() >= base + 10) break;
        @(posedge clk); #1 res_ready = ~res_ready;
        if (issued - popped > worst) worst = issued - popped;
      end
    join
    res_ready = 1'b1;
    wait_n(base + 10);
    checks++;
    if (worst > 2) begin errors++; $display("FAIL toggle_credit: in_flight=%0d required <=2", worst); end
    for (int i = 0; i < 10; i++) begin
      if (base + i >= got_d.size()) break;
      checks++;
      if (got_d[base+i] !== alu_ref(2'(i % 2), 4'(i + 1), 4'd3) || got_t[base+i] !== 3'(i % 8)) begin
        errors++; $display("FAIL toggle%0d: data=%b tag=%0d required %b %0d", i, got_d[base+i], got_t[base+i],
                           alu_ref(2'(i % 2), 4'(i + 1), 4'd3), i % 8);
      end
    end
    checks++;
    if (got_d.size() != base + 10) begin errors++; $display("FAIL toggle_count: %0d required 10", got_d.size() - base); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_tag_wrap();
    test_reset_mid();
    test_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream operand/opcode issue stage for the 4-bit registered ALU (ALU_4_bit).
- Buffers incoming operations in a small command FIFO and drives Opcode/A/B to the ALU at most one per cycle.
- Tracks the ALU's 1-cycle registered latency and captures each C result into a 2-entry result buffer, with a tag and a valid/ready handshake toward the consumer.
- Throttles issue with credits so that no ALU result is ever lost under consumer backpressure.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, minimum 2).
- TAG_W, 3, width of the result sequence tag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command FIFO not full.
- in_opcode  in  2  00 add, 01 sub, 10 ~A, 11 |B.
- in_a  in  4  signed operand A.
- in_b  in  4  signed operand B.
- alu_opcode  out  2  to ALU Opcode.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_c  in  5  from ALU C (registered, signed).
- res_valid  out  1  result buffer non-empty.
- res_ready  in  1  consumer accepts the result.
- res_data  out  5  signed result, head of result buffer.
- res_tag  out  TAG_W  issue sequence number of res_data.
- busy  out  1  FIFO non-empty, or op pending, or result buffer non-empty.

Behaviour:
- Reset (async): FIFO empty, pending=0, result buffer empty, issue tag counter=0.
  - Outputs after reset: in_ready=1, res_valid=0, res_data=0, res_tag=0, alu_opcode/alu_a/alu_b=0, busy=0.
- Command push: occurs when in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH).
  - A push into a full FIFO is impossible by construction, because in_ready=0 when full.
- Issue in cycle N requires all of:
  - FIFO non-empty.
  - (res_count + pending − res_pop) < 2, where res_pop = res_valid && res_ready in cycle N.
- On issue:
  - alu_* driven combinationally from the FIFO head during cycle N; the head is popped at the edge ending N.
  - pending<=1 and pend_tag<=tag_cnt; tag_cnt increments, wrapping mod 2^TAG_W.
- When not issuing: alu_opcode/alu_a/alu_b = 0, pending<=0.
- Capture: if pending=1 in cycle N+1, alu_c (the ALU register output) is written into the result buffer with pend_tag at the edge ending N+1.
- Push and pop in the same cycle:
  - Simultaneous command push and issue-pop on the FIFO is allowed; count is unchanged.
  - Simultaneous capture and res_pop on the result buffer is allowed; count is unchanged, order preserved.
- Throughput: with res_ready held at 1, one result per cycle; first res_valid appears 2 cycles after the issue edge.
- Ordering: results leave in strict issue order; tags are consecutive.
- Backpressure:
  - res_data/res_tag hold stable while res_valid && !res_ready.
  - Credits cap in-flight ops (pending + buffered) at 2.
- Width: res_data is alu_c unmodified; no sign extension or saturation is applied in this block.
- Reset mid-operation: FIFO, pending op and buffered results are all discarded; the ALU is reset on the same reset net.

Test Plan:
- Push add A=3,B=2 with res_ready=1 -> res_valid rises 2 cycles after issue, res_data=5, res_tag=0, busy falls the cycle after the pop.
- Push sub A=−3,B=4, then ~A A=5, then |B B=8, then |B B=0 back-to-back -> results in order: −7 (5'b11001), −6 (5'b11010), 1, 0; tags 0,1,2,3; one result per cycle.
- Hold res_ready=0 and push 6 commands:
  - Exactly 2 ops issue; the FIFO fills to 4 and in_ready=0.
  - res_data=first result stays stable.
  - Raising res_ready drains all 6 in order with no loss.
- Push 9 commands to exercise tag wrap with TAG_W=3 -> tags 0..7 then 0.
- Assert reset while the FIFO has 3 entries and 1 op is pending -> next cycle res_valid=0, in_ready=1, busy=0, tag restarts at 0.
- Toggle res_ready every cycle under continuous input -> no duplicated or dropped results, credit never exceeded (pending + res_count ≤ 2).
